// File: rtl/uart_rx_if.sv
// uart_rx_if: valid/ready word handshake between uart_rx and its consumer.
interface uart_rx_if #(
    parameter int DATA_W = 8
);
    logic              rvalid;
    logic              rready;
    logic [DATA_W-1:0] rdata;

    modport master (output rvalid, output rdata, input rready);
    modport slave  (input rvalid, input rdata, output rready);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 LSB-first UART receiver assembling BYTE_WIDTH bytes per word,
// presented on a valid/ready output register.
// Optional macro UART_RX_TIMEOUT_EN: clears a partial word after 20 idle bit times.
module uart_rx #(
    parameter int UART_CLK_DIV = 434,
    parameter int BYTE_WIDTH   = 1,
    parameter int BIG_ENDIAN   = 0
) (
    input  logic      clk,
    input  logic      rstn,
    input  logic      i_uart_rx,
    uart_rx_if.master rx_bus,
    output logic      o_frame_err,
    output logic      o_overflow
);
    localparam int W     = BYTE_WIDTH * 8;
    localparam int CNT_W = $clog2(UART_CLK_DIV);
    localparam int BC_W  = (BYTE_WIDTH > 1) ? $clog2(BYTE_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(UART_CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(UART_CLK_DIV / 2 - 1);
    localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(BYTE_WIDTH - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

    logic             r_sync1, r_sync2;
    state_t           r_state, w_state;
    logic [CNT_W-1:0] r_cnt, w_cnt;
    logic [2:0]       r_bitidx, w_bitidx;
    logic [7:0]       r_shift, w_shift;
    logic [BC_W-1:0]  r_bytecnt;
    logic [W-1:0]     r_rdata;
    logic             r_rvalid, r_frame_err, r_overflow;
    logic             w_rx_s, w_byte_good, w_ferr, w_complete, w_timeout;
    logic [W-1:0]     w_word_ins;

    assign w_rx_s     = r_sync2;
    assign w_complete = w_byte_good && (r_bytecnt == BC_LAST);

    // Partial register holds only the bytes received before the current one;
    // the current byte is merged in combinationally when the word completes.
    if (BYTE_WIDTH == 1) begin : g_single
        assign w_word_ins = r_shift;
    end else begin : g_multi
        localparam int PW = W - 8;
        logic [PW-1:0] r_part;

        if (BIG_ENDIAN == 0) begin : g_msb_first
            assign w_word_ins = {r_part, r_shift};
        end else begin : g_lsb_first
            assign w_word_ins = {r_shift, r_part};
        end

        // Partial word: cleared on framing error or timeout, updated per good byte
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                r_part <= '0;
            end else if (w_ferr || w_timeout) begin
                r_part <= '0;
            end else if (w_byte_good) begin
                r_part <= (BIG_ENDIAN == 0) ? w_word_ins[PW-1:0] : w_word_ins[W-1:8];
            end
        end
    end

`ifdef UART_RX_TIMEOUT_EN
    localparam int TMO_CYC = 20 * UART_CLK_DIV;
    localparam int TMO_W   = $clog2(TMO_CYC);
    logic [TMO_W-1:0] r_idle_cnt;

    assign w_timeout = (r_state == S_IDLE) && (r_bytecnt != '0) && w_rx_s &&
                       (r_idle_cnt == TMO_W'(TMO_CYC - 1));

    // Idle counter: runs only while idle with a partial word pending
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_idle_cnt <= '0;
        end else if ((r_state == S_IDLE) && (r_bytecnt != '0) && w_rx_s && !w_timeout) begin
            r_idle_cnt <= r_idle_cnt + TMO_W'(1);
        end else begin
            r_idle_cnt <= '0;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // Synchronizer and frame state registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_bitidx <= '0;
            r_shift  <= '0;
        end else begin
            r_sync1  <= i_uart_rx;
            r_sync2  <= r_sync1;
            r_state  <= w_state;
            r_cnt    <= w_cnt;
            r_bitidx <= w_bitidx;
            r_shift  <= w_shift;
        end
    end

    // Next-state: start qualification, bit sampling, stop check
    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_bitidx    = r_bitidx;
        w_shift     = r_shift;
        w_byte_good = 1'b0;
        w_ferr      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt = '0;
                if (!w_rx_s) w_state = S_START;
            end
            S_START: begin
                if (r_cnt == CNT_MID) begin
                    w_cnt    = '0;
                    w_bitidx = '0;
                    w_state  = w_rx_s ? S_IDLE : S_DATA;
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt    = '0;
                    w_shift  = {w_rx_s, r_shift[7:1]};
                    w_bitidx = r_bitidx + 3'd1;
                    if (r_bitidx == 3'd7) w_state = S_STOP;
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt = '0;
                    if (w_rx_s) begin
                        w_byte_good = 1'b1;
                        w_state     = S_IDLE;
                    end else begin
                        w_ferr  = 1'b1;
                        w_state = S_BREAK;
                    end
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            S_BREAK: begin
                if (w_rx_s) w_state = S_IDLE;
            end
            default: w_state = S_IDLE;
        endcase
    end

    // Byte counter within the current word
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_bytecnt <= '0;
        end else if (w_ferr || w_timeout) begin
            r_bytecnt <= '0;
        end else if (w_byte_good) begin
            r_bytecnt <= (r_bytecnt == BC_LAST) ? '0 : r_bytecnt + BC_W'(1);
        end
    end

    // Output register with overflow and error pulses
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rvalid    <= 1'b0;
            r_rdata     <= '0;
            r_frame_err <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_frame_err <= w_ferr;
            r_overflow  <= w_complete && r_rvalid && !rx_bus.rready;
            if (w_complete) begin
                if (!r_rvalid || rx_bus.rready) begin
                    r_rdata  <= w_word_ins;
                    r_rvalid <= 1'b1;
                end
            end else if (r_rvalid && rx_bus.rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    assign rx_bus.rvalid = r_rvalid;
    assign rx_bus.rdata  = r_rdata;
    assign o_frame_err   = r_frame_err;
    assign o_overflow    = r_overflow;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: three uart_rx instances (BW=1; BW=2 MSB-first; BW=2 LSB-first)
// share one serial line and are compared each cycle against a word-level model.
module tb_uart_rx;
    localparam int DIV = 8;
`ifdef UART_RX_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    typedef struct {
        int     at_edge;
        bit [7:0] data;
        bit     good;
        bit     tmo;
    } ev_t;

    logic clk    = 1'b0;
    logic rstn   = 1'b0;
    logic line   = 1'b1;
    logic rready = 1'b0;
    bit   rnd_en = 1'b0;
    bit   rdy_dir = 1'b0;

    always #5 clk = ~clk;

    always @(negedge clk) rready = rnd_en ? 1'($urandom_range(0, 1)) : rdy_dir;

    uart_rx_if #(.DATA_W(8))  bus0 ();
    uart_rx_if #(.DATA_W(16)) bus1 ();
    uart_rx_if #(.DATA_W(16)) bus2 ();
    assign bus0.rready = rready;
    assign bus1.rready = rready;
    assign bus2.rready = rready;

    logic [2:0]  d_ferr, d_ovf, d_vld;
    logic [15:0] d_data [3];

    uart_rx #(.UART_CLK_DIV(DIV), .BYTE_WIDTH(1), .BIG_ENDIAN(0)) u_dut0 (
        .clk(clk), .rstn(rstn), .i_uart_rx(line), .rx_bus(bus0),
        .o_frame_err(d_ferr[0]), .o_overflow(d_ovf[0]));
    uart_rx #(.UART_CLK_DIV(DIV), .BYTE_WIDTH(2), .BIG_ENDIAN(0)) u_dut1 (
        .clk(clk), .rstn(rstn), .i_uart_rx(line), .rx_bus(bus1),
        .o_frame_err(d_ferr[1]), .o_overflow(d_ovf[1]));
    uart_rx #(.UART_CLK_DIV(DIV), .BYTE_WIDTH(2), .BIG_ENDIAN(1)) u_dut2 (
        .clk(clk), .rstn(rstn), .i_uart_rx(line), .rx_bus(bus2),
        .o_frame_err(d_ferr[2]), .o_overflow(d_ovf[2]));

    assign d_vld[0]  = bus0.rvalid;
    assign d_vld[1]  = bus1.rvalid;
    assign d_vld[2]  = bus2.rvalid;
    assign d_data[0] = {8'h00, bus0.rdata};
    assign d_data[1] = bus1.rdata;
    assign d_data[2] = bus2.rdata;

    int checks = 0;
    int errors = 0;
    int nprint = 0;
    int n_vld [3];
    int n_ferr [3];
    int n_ovf [3];

    task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (nprint < 40) begin
                nprint++;
                $display("FAIL %s dut%0d got %h expected %h at cycle-time %0t", name, idx, act, exp, $time);
            end
        end
    endtask

    // Word-level model: each frame becomes an event at the edge where the
    // receiver's output register must reflect the stop-bit decision.
    int          cyc = 0;
    ev_t         evq [$];
    bit          m_vld  [3];
    bit [15:0]   m_data [3];
    bit [15:0]   m_part [3];
    int          m_cnt  [3];
    bit          m_ferr [3];
    bit          m_ovf  [3];

    always @(posedge clk) begin : model
        ev_t       ev;
        bit        have;
        bit        comp;
        int        bw;
        bit [15:0] mask;
        cyc  = cyc + 1;
        have = 1'b0;
        if (evq.size() > 0 && evq[0].at_edge == cyc) begin
            ev   = evq.pop_front();
            have = 1'b1;
        end
        for (int i = 0; i < 3; i++) begin
            m_ferr[i] = 1'b0;
            m_ovf[i]  = 1'b0;
            comp      = 1'b0;
            bw        = (i == 0) ? 1 : 2;
            mask      = (bw == 1) ? 16'h00FF : 16'hFFFF;
            if (!rstn) begin
                m_vld[i]  = 1'b0;
                m_data[i] = '0;
                m_part[i] = '0;
                m_cnt[i]  = 0;
            end else begin
                if (have) begin
                    if (ev.tmo && TMO_EN) begin
                        m_part[i] = '0;
                        m_cnt[i]  = 0;
                    end
                    if (ev.good) begin
                        if (i == 2) m_part[i] = ((m_part[i] >> 8) | (16'(ev.data) << (8 * (bw - 1)))) & mask;
                        else        m_part[i] = ((m_part[i] << 8) | 16'(ev.data)) & mask;
                        m_cnt[i] = m_cnt[i] + 1;
                        if (m_cnt[i] == bw) begin
                            comp     = 1'b1;
                            m_cnt[i] = 0;
                        end
                    end else begin
                        m_ferr[i] = 1'b1;
                        m_part[i] = '0;
                        m_cnt[i]  = 0;
                    end
                end
                if (comp) begin
                    if (!m_vld[i] || rready) begin
                        m_data[i] = m_part[i];
                        m_vld[i]  = 1'b1;
                    end else begin
                        m_ovf[i] = 1'b1;
                    end
                end else if (m_vld[i] && rready) begin
                    m_vld[i] = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        for (int i = 0; i < 3; i++) begin
            chk("rvalid", i, 16'(d_vld[i]), 16'(m_vld[i]));
            chk("rdata", i, d_data[i], m_data[i]);
            chk("frame_err", i, 16'(d_ferr[i]), 16'(m_ferr[i]));
            chk("overflow", i, 16'(d_ovf[i]), 16'(m_ovf[i]));
            if (d_vld[i] === 1'b1)  n_vld[i]++;
            if (d_ferr[i] === 1'b1) n_ferr[i]++;
            if (d_ovf[i] === 1'b1)  n_ovf[i]++;
        end
    end

    // Drives one frame starting at a negedge; gap_bits of idle precede it.
    task automatic send(input bit [7:0] b, input bit good, input int gap_bits, input bit glitch, input int brk_bits);
        ev_t ev;
        if (gap_bits > 0) begin
            if (glitch && gap_bits >= 2) begin
                line = 1'b1; repeat (2) @(negedge clk);
                line = 1'b0; repeat (2) @(negedge clk);
                line = 1'b1; repeat (gap_bits * DIV - 4) @(negedge clk);
            end else begin
                line = 1'b1; repeat (gap_bits * DIV) @(negedge clk);
            end
        end
        line       = 1'b0;
        // 2 synchronizer edges + 1 to enter START, then half a bit plus 9 bits to the stop sample
        ev.at_edge = cyc + 3 + DIV / 2 + 9 * DIV;
        ev.data    = b;
        ev.good    = good;
        ev.tmo     = (gap_bits >= 20);
        evq.push_back(ev);
        repeat (DIV) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            line = b[k];
            repeat (DIV) @(negedge clk);
        end
        line = good;
        repeat (DIV) @(negedge clk);
        if (!good) repeat (brk_bits * DIV) @(negedge clk);
    endtask

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bit [7:0] b;
        bit       good, glitch, prev_bad;
        int       gap, brk;

        repeat (3) @(negedge clk);
        chk("reset_rvalid", 0, 16'(d_vld), 16'h0000);
        chk("reset_rdata", 1, d_data[1], 16'h0000);
        chk("reset_pulses", 0, 16'({d_ferr, d_ovf}), 16'h0000);
        rstn = 1'b1;
        repeat (4) @(negedge clk);

        // back-to-back 0x55, 0xA3 with consumer always ready
        rdy_dir = 1'b1;
        @(negedge clk);
        send(8'h55, 1'b1, 0, 1'b0, 0);
        chk("lit_bw1_55", 0, d_data[0], 16'h0055);
        send(8'hA3, 1'b1, 0, 1'b0, 0);
        chk("lit_bw1_a3", 0, d_data[0], 16'h00A3);
        chk("lit_be0_55a3", 1, d_data[1], 16'h55A3);
        chk("lit_be1_a355", 2, d_data[2], 16'hA355);
        chk("lit_bw1_vld_cycles", 0, 16'(n_vld[0]), 16'd2);

        // two-byte word ordering
        send(8'h12, 1'b1, 1, 1'b0, 0);
        send(8'h34, 1'b1, 0, 1'b0, 0);
        chk("lit_be0_1234", 1, d_data[1], 16'h1234);
        chk("lit_be1_3412", 2, d_data[2], 16'h3412);

        // 2-cycle low glitch on idle line
        line = 1'b0; repeat (2) @(negedge clk);
        line = 1'b1; repeat (3 * DIV) @(negedge clk);
        chk("lit_glitch_vld_cycles", 0, 16'(n_vld[0]), 16'd4);
        chk("lit_glitch_no_ferr", 0, 16'(n_ferr[0] + n_ferr[1] + n_ferr[2]), 16'd0);

        // framing error followed by a 30-bit break, then recovery
        send(8'h7E, 1'b0, 1, 1'b0, 30);
        send(8'h41, 1'b1, 1, 1'b0, 0);
        chk("lit_break_ferr_once", 0, 16'(n_ferr[0]), 16'd1);
        chk("lit_break_ferr_once", 2, 16'(n_ferr[2]), 16'd1);
        chk("lit_after_break_41", 0, d_data[0], 16'h0041);
        send(8'h42, 1'b1, 0, 1'b0, 0);
        chk("lit_be0_4142", 1, d_data[1], 16'h4142);
        chk("lit_be1_4241", 2, d_data[2], 16'h4241);

        // overflow with consumer stalled
        rdy_dir = 1'b0;
        send(8'h01, 1'b1, 1, 1'b0, 0);
        send(8'h02, 1'b1, 0, 1'b0, 0);
        chk("lit_ovf_keep_01", 0, d_data[0], 16'h0001);
        chk("lit_ovf_once", 0, 16'(n_ovf[0]), 16'd1);
        chk("lit_ovf_none_bw2", 1, 16'(n_ovf[1]), 16'd0);
        chk("lit_be0_0102", 1, d_data[1], 16'h0102);
        rdy_dir = 1'b1;
        repeat (3) @(negedge clk);
        chk("lit_drain_vld", 0, 16'(d_vld), 16'h0000);

        // long idle gap between bytes of one word
        send(8'hAA, 1'b1, 1, 1'b0, 0);
        send(8'h11, 1'b1, 25, 1'b0, 0);
`ifndef UART_RX_TIMEOUT_EN
        chk("lit_hold_aa11", 1, d_data[1], 16'hAA11);
        chk("lit_hold_11aa", 2, d_data[2], 16'h11AA);
`endif
        send(8'h22, 1'b1, 0, 1'b0, 0);
`ifdef UART_RX_TIMEOUT_EN
        chk("lit_tmo_1122", 1, d_data[1], 16'h1122);
        chk("lit_tmo_2211", 2, d_data[2], 16'h2211);
`endif

        // randomized frames, gaps, glitches, errors and consumer stalls
        rnd_en   = 1'b1;
        prev_bad = 1'b0;
        for (int n = 0; n < 120; n++) begin
            b      = 8'($urandom);
            good   = ($urandom_range(0, 7) != 0);
            gap    = prev_bad ? int'($urandom_range(1, 2)) : int'($urandom_range(0, 2));
            glitch = (gap == 2) && ($urandom_range(0, 1) == 1);
            brk    = int'($urandom_range(0, 3));
            send(b, good, gap, glitch, brk);
            prev_bad = !good;
        end
        line = 1'b1;
        repeat (3 * DIV) @(negedge clk);
        rnd_en = 1'b0;
        chk("events_drained", 0, 16'(evq.size()), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
